i2c_status_regfile: RTL and testbench
=====================================

Name: i2c_status_regfile

Overview:
- Parametrised successor to the I2C slave register interface; sits between the i2cSlave core (addr/dataIn/writeEn/readEn) and the video/OSD core.
- Provides NUM_CFG read/write configuration bytes with per-register reset defaults and change strobes.
- Provides NUM_CNT 32-bit event counters read atomically through a snapshot shadow, fixed-length action pulses, and sticky status bits with write-1-to-clear and a masked irq.

Parameters:
NUM_CFG, 8, number of 8-bit R/W config registers at CFG_BASE..CFG_BASE+NUM_CFG-1
CFG_BASE, 8'h90, first config address
CFG_RESET, {NUM_CFG{8'h00}}, packed reset values; byte i is the default for cfg i
NUM_CNT, 6, number of 32-bit counters; counter k occupies CNT_BASE+4k..+4k+3, MSB first
CNT_BASE, 8'hA0, first counter address
NUM_PULSE, 2, number of action pulse outputs at PULSE_BASE+i
PULSE_BASE, 8'hF0, first pulse address
PULSE_LEN, 4, pulse width in clk cycles (>=1)
STICKY_BASE, 8'hC8, sticky status address; STICKY_BASE+1 is the irq mask

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
addr  in  8  register address from i2cSlave
dataIn  in  8  write data
writeEn  in  1  one-cycle write strobe
readEn  in  1  one-cycle strobe; byte at addr consumed by master
dataOut  out  8  registered read data
cfg_out  out  NUM_CFG*8  config register contents; byte i = cfg i
cfg_changed  out  NUM_CFG  one-cycle strobe per config register written
cnt_in  in  NUM_CNT*32  live counter values; word k = counter k
pulse_out  out  NUM_PULSE  action pulses
event_in  in  8  sticky set inputs (level, clk domain)
sticky_out  out  8  sticky status bits
irq  out  1  |(sticky & mask), registered

Behaviour:
- Reset values: dataOut=0, cfg_out=CFG_RESET, cfg_changed=0, pulse_out=0, sticky=0, mask=0, irq=0, snapshot invalid.
- Read path: dataOut is updated every cycle from addr with one-cycle latency. Unmapped addresses read 0.
  - Config address: returns the register byte.
  - STICKY_BASE: returns sticky; STICKY_BASE+1 returns mask.
  - Pulse addresses: return {7'd0, pulse_out[i]}.
- Counter snapshot:
  - Byte 0 (MSB) of counter k always reads live cnt_in[k][31:24].
  - readEn at byte 0 of counter k loads the shadow with the full 32-bit cnt_in[k] from that cycle, sets snap_idx=k and snap_valid=1.
  - Bytes 1..3 of counter k return the shadow byte when snap_valid && snap_idx==k, else the live byte.
  - readEn at byte 0 of a different counter replaces the shadow. Any write clears snap_valid.
- Config write: writeEn at config i loads dataIn next cycle and pulses cfg_changed[i] for exactly 1 cycle, even if the value is unchanged.
- Pulses:
  - writeEn at PULSE_BASE+i (data ignored) asserts pulse_out[i] from the next cycle for PULSE_LEN cycles, driven by a per-channel down-counter.
  - A rewrite while active reloads the counter, so the pulse is extended, never split.
  - Channels are independent.
- Sticky:
  - Per cycle: sticky[b] <= event_in[b] | (sticky[b] & ~(wr_clr & dataIn[b])), where wr_clr = writeEn at STICKY_BASE.
  - Set wins over a simultaneous clear.
  - Writing STICKY_BASE+1 loads mask.
  - irq is registered one cycle after sticky/mask.
- writeEn and readEn in the same cycle: the write takes effect; the read snapshot is still taken if its condition holds.
- Reset assertion mid-pulse or mid-snapshot returns everything to reset values immediately (asynchronous).
- Address-range overlap between regions is illegal; guarded by an elaboration-time assertion.

Decomposition:
- Package i2c_regs_pkg: address map constants (CFG_BASE, CNT_BASE, PULSE_BASE, STICKY_BASE), counter byte-lane helper function, and a typedef for the snapshot state (idx, valid, data).
- Sub-module: i2c_pulse_stretcher (one channel: trigger in, PULSE_LEN down-counter, pulse out, async reset), instantiated NUM_PULSE times in a generate loop.

Test Plan:
- Reset: release reset_n -> cfg_out==CFG_RESET, dataOut==0, irq==0; read 8'h91 -> dataOut==CFG_RESET byte 1 one cycle after addr.
- Atomic counter:
  - cnt_in[1]=32'h00FF_FFFF, readEn at 8'hA4 (dataOut 8'h00).
  - Counter then rolls to 32'h0100_0000.
  - Reads A5/A6/A7 -> 8'hFF, 8'hFF, 8'hFF (shadow, not live).
- Pulse: writeEn at 8'hF0 -> pulse_out[0] high exactly 4 cycles; a second write on cycle 3 -> high 6 cycles total; pulse_out[1] stays 0.
- Sticky:
  - event_in=8'h05 for 1 cycle -> sticky==8'h05.
  - Write 8'h04 to 8'hC8 -> sticky==8'h01.
  - Write 8'h01 while event_in[0]=1 -> sticky[0] stays 1.
- Irq: mask=8'h02 via 8'hC9, event_in[1] pulse -> irq rises 2 cycles after the event; clearing sticky[1] drops irq 1 cycle later.
- Config strobe: write 8'h3C to 8'h93 -> cfg_out byte 3 == 8'h3C, cfg_changed==8'b0000_1000 for one cycle; reset_n low mid-pulse -> all outputs reset asynchronously.

Source files
------------

// File: rtl/i2c_regs_pkg.sv
// Address map defaults, counter byte-lane selection and snapshot state shared by the
// I2C status register file and its pulse channels.
package i2c_regs_pkg;

  localparam logic [7:0] CFG_BASE_DEF    = 8'h90;
  localparam logic [7:0] CNT_BASE_DEF    = 8'hA0;
  localparam logic [7:0] PULSE_BASE_DEF  = 8'hF0;
  localparam logic [7:0] STICKY_BASE_DEF = 8'hC8;
  localparam int         CNT_BYTES       = 4;

  typedef struct packed {
    logic [7:0]  idx;
    logic        valid;
    logic [31:0] data;
  } snap_t;

  // Counters are presented MSB first: lane 0 is bits 31:24.
  function automatic logic [7:0] cnt_byte(input logic [31:0] word, input logic [1:0] lane);
    case (lane)
      2'd0:    cnt_byte = word[31:24];
      2'd1:    cnt_byte = word[23:16];
      2'd2:    cnt_byte = word[15:8];
      default: cnt_byte = word[7:0];
    endcase
  endfunction

  function automatic logic ranges_overlap(input int a_lo, input int a_n,
                                          input int b_lo, input int b_n);
    ranges_overlap = (a_lo < b_lo + b_n) && (b_lo < a_lo + a_n);
  endfunction

endpackage

// File: rtl/i2c_pulse_stretcher.sv
// One action-pulse channel: a trigger (re)loads a down-counter and the output stays high
// for PULSE_LEN cycles after the last trigger.
module i2c_pulse_stretcher #(
  parameter int PULSE_LEN = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_trigger,
  output logic o_pulse
);

  localparam int CW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

  logic [CW-1:0] r_remain;
  logic          r_pulse;

  // r_remain counts the high cycles still owed after the current one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_remain <= '0;
      r_pulse  <= 1'b0;
    end else if (i_trigger) begin
      r_remain <= CW'(PULSE_LEN - 1);
      r_pulse  <= 1'b1;
    end else if (r_remain != '0) begin
      r_remain <= r_remain - 1'b1;
      r_pulse  <= 1'b1;
    end else begin
      r_remain <= '0;
      r_pulse  <= 1'b0;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/i2c_status_regfile.sv
// Register file between the i2cSlave core and the video/OSD core: config bytes with change
// strobes, atomically readable 32-bit counters, action pulses and sticky status with irq.
module i2c_status_regfile
  import i2c_regs_pkg::*;
#(
  parameter int                   NUM_CFG     = 8,
  parameter logic [7:0]           CFG_BASE    = CFG_BASE_DEF,
  parameter logic [NUM_CFG*8-1:0] CFG_RESET   = {NUM_CFG{8'h00}},
  parameter int                   NUM_CNT     = 6,
  parameter logic [7:0]           CNT_BASE    = CNT_BASE_DEF,
  parameter int                   NUM_PULSE   = 2,
  parameter logic [7:0]           PULSE_BASE  = PULSE_BASE_DEF,
  parameter int                   PULSE_LEN   = 4,
  parameter logic [7:0]           STICKY_BASE = STICKY_BASE_DEF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [7:0]              addr,
  input  logic [7:0]              dataIn,
  input  logic                    writeEn,
  input  logic                    readEn,
  output logic [7:0]              dataOut,
  output logic [NUM_CFG*8-1:0]    cfg_out,
  output logic [NUM_CFG-1:0]      cfg_changed,
  input  logic [NUM_CNT*32-1:0]   cnt_in,
  output logic [NUM_PULSE-1:0]    pulse_out,
  input  logic [7:0]              event_in,
  output logic [7:0]              sticky_out,
  output logic                    irq
);

  if (ranges_overlap(int'(CFG_BASE), NUM_CFG, int'(CNT_BASE), CNT_BYTES*NUM_CNT) ||
      ranges_overlap(int'(CFG_BASE), NUM_CFG, int'(PULSE_BASE), NUM_PULSE) ||
      ranges_overlap(int'(CFG_BASE), NUM_CFG, int'(STICKY_BASE), 2) ||
      ranges_overlap(int'(CNT_BASE), CNT_BYTES*NUM_CNT, int'(PULSE_BASE), NUM_PULSE) ||
      ranges_overlap(int'(CNT_BASE), CNT_BYTES*NUM_CNT, int'(STICKY_BASE), 2) ||
      ranges_overlap(int'(PULSE_BASE), NUM_PULSE, int'(STICKY_BASE), 2)) begin : g_map_overlap
    $error("i2c_status_regfile: register regions overlap");
  end

  logic [NUM_CFG*8-1:0] r_cfg;
  logic [NUM_CFG-1:0]   r_cfg_changed;
  logic [7:0]           r_data_out;
  logic [7:0]           r_sticky;
  logic [7:0]           r_mask;
  logic                 r_irq;
  snap_t                r_snap;

  logic [7:0]           w_rd_data;
  logic [NUM_CFG-1:0]   w_cfg_wr;
  logic [NUM_PULSE-1:0] w_pulse;
  logic                 w_sticky_clr;
  logic                 w_mask_wr;
  logic                 w_snap_load;
  logic [7:0]           w_snap_idx;
  logic [31:0]          w_snap_data;

  for (genvar i = 0; i < NUM_CFG; i++) begin : g_cfg_dec
    assign w_cfg_wr[i] = writeEn && (addr == 8'(CFG_BASE + i));
  end

  assign w_sticky_clr = writeEn && (addr == STICKY_BASE);
  assign w_mask_wr    = writeEn && (addr == 8'(STICKY_BASE + 1));

  for (genvar p = 0; p < NUM_PULSE; p++) begin : g_pulse
    i2c_pulse_stretcher #(.PULSE_LEN(PULSE_LEN)) u_stretch (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_trigger (writeEn && (addr == 8'(PULSE_BASE + p))),
      .o_pulse   (w_pulse[p])
    );
  end

  // Read mux; lanes 1..3 of the snapshotted counter come from the shadow so a multi-byte
  // read sees one coherent value even if the live counter carries between bytes.
  always_comb begin
    w_rd_data = 8'h00;
    for (int i = 0; i < NUM_CFG; i++) begin
      if (addr == 8'(CFG_BASE + i)) w_rd_data = r_cfg[i*8 +: 8];
    end
    for (int k = 0; k < NUM_CNT; k++) begin
      for (int b = 0; b < CNT_BYTES; b++) begin
        if (addr == 8'(CNT_BASE + CNT_BYTES*k + b)) begin
          if (b != 0 && r_snap.valid && r_snap.idx == 8'(k)) w_rd_data = cnt_byte(r_snap.data, 2'(b));
          else w_rd_data = cnt_byte(cnt_in[k*32 +: 32], 2'(b));
        end
      end
    end
    if (addr == STICKY_BASE) w_rd_data = r_sticky;
    if (addr == 8'(STICKY_BASE + 1)) w_rd_data = r_mask;
    for (int p = 0; p < NUM_PULSE; p++) begin
      if (addr == 8'(PULSE_BASE + p)) w_rd_data = {7'd0, w_pulse[p]};
    end
  end

  // Consuming the MSB of a counter captures the whole word for the following lane reads.
  always_comb begin
    w_snap_load = 1'b0;
    w_snap_idx  = 8'h00;
    w_snap_data = 32'h0000_0000;
    for (int k = 0; k < NUM_CNT; k++) begin
      if (readEn && addr == 8'(CNT_BASE + CNT_BYTES*k)) begin
        w_snap_load = 1'b1;
        w_snap_idx  = 8'(k);
        w_snap_data = cnt_in[k*32 +: 32];
      end
    end
  end

  // Config bytes, their change strobes and the registered read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cfg         <= CFG_RESET;
      r_cfg_changed <= '0;
      r_data_out    <= 8'h00;
    end else begin
      for (int i = 0; i < NUM_CFG; i++) begin
        if (w_cfg_wr[i]) r_cfg[i*8 +: 8] <= dataIn;
      end
      r_cfg_changed <= w_cfg_wr;
      r_data_out    <= w_rd_data;
    end
  end

  // Sticky status: a live event always wins over a simultaneous write-1-to-clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sticky <= 8'h00;
      r_mask   <= 8'h00;
      r_irq    <= 1'b0;
    end else begin
      r_sticky <= event_in | (r_sticky & ~(dataIn & {8{w_sticky_clr}}));
      if (w_mask_wr) r_mask <= dataIn;
      r_irq <= |(r_sticky & r_mask);
    end
  end

  // A snapshot request outranks the invalidation caused by a write in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_snap <= '0;
    end else if (w_snap_load) begin
      r_snap.idx   <= w_snap_idx;
      r_snap.valid <= 1'b1;
      r_snap.data  <= w_snap_data;
    end else if (writeEn) begin
      r_snap.valid <= 1'b0;
    end
  end

  assign dataOut     = r_data_out;
  assign cfg_out     = r_cfg;
  assign cfg_changed = r_cfg_changed;
  assign pulse_out   = w_pulse;
  assign sticky_out  = r_sticky;
  assign irq         = r_irq;

endmodule

// File: tb/tb_i2c_status_regfile.sv
// Self-checking bench for i2c_status_regfile: directed vector table, hand-written pulse,
// strobe and async-reset sequences, then randomized traffic against a behavioural model.
module tb_i2c_status_regfile;

  localparam int NUM_CFG   = 8;
  localparam int NUM_CNT   = 6;
  localparam int NUM_PULSE = 2;
  localparam int PULSE_LEN = 4;
  localparam int CFG_B     = int'(8'h90);
  localparam int CNT_B     = int'(8'hA0);
  localparam int PUL_B     = int'(8'hF0);
  localparam int STK_B     = int'(8'hC8);
  localparam logic [NUM_CFG*8-1:0] CFG_RST = 64'h7766_5544_3322_1100;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic [7:0]             addr;
  logic [7:0]             dataIn;
  logic                   writeEn;
  logic                   readEn;
  logic [7:0]             dataOut;
  logic [NUM_CFG*8-1:0]   cfg_out;
  logic [NUM_CFG-1:0]     cfg_changed;
  logic [NUM_CNT*32-1:0]  cnt_in;
  logic [NUM_PULSE-1:0]   pulse_out;
  logic [7:0]             event_in;
  logic [7:0]             sticky_out;
  logic                   irq;

  always #5 clk = ~clk;

  i2c_status_regfile #(
    .NUM_CFG(NUM_CFG), .CFG_BASE(8'h90), .CFG_RESET(CFG_RST),
    .NUM_CNT(NUM_CNT), .CNT_BASE(8'hA0), .NUM_PULSE(NUM_PULSE),
    .PULSE_BASE(8'hF0), .PULSE_LEN(PULSE_LEN), .STICKY_BASE(8'hC8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .addr(addr), .dataIn(dataIn), .writeEn(writeEn),
    .readEn(readEn), .dataOut(dataOut), .cfg_out(cfg_out), .cfg_changed(cfg_changed),
    .cnt_in(cnt_in), .pulse_out(pulse_out), .event_in(event_in), .sticky_out(sticky_out),
    .irq(irq)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural reference state.
  logic [7:0]         m_cfg [NUM_CFG];
  logic [7:0]         m_sticky;
  logic [7:0]         m_mask;
  int                 m_rem [NUM_PULSE];
  bit                 m_snap_v;
  int                 m_snap_k;
  logic [31:0]        m_snap_d;
  logic [7:0]         e_dout;
  logic               e_irq;
  logic [NUM_CFG-1:0] e_chg;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  d;
    bit          we;
    bit          re;
    logic [7:0]  ev;
    logic [31:0] c1;
    bit          cd;
    logic [7:0]  ed;
    bit          cs;
    logic [7:0]  es;
    bit          ci;
    bit          ei;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [7:0] a, logic [7:0] d, bit we, bit re, logic [7:0] ev,
                              logic [31:0] c1, bit cd, logic [7:0] ed, bit cs, logic [7:0] es,
                              bit ci, bit ei);
    vec_t v;
    v.a = a; v.d = d; v.we = we; v.re = re; v.ev = ev; v.c1 = c1;
    v.cd = cd; v.ed = ed; v.cs = cs; v.es = es; v.ci = ci; v.ei = ei;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NUM_CFG; i++) m_cfg[i] = CFG_RST[i*8 +: 8];
    for (int i = 0; i < NUM_PULSE; i++) m_rem[i] = 0;
    m_sticky = 8'h00;
    m_mask   = 8'h00;
    m_snap_v = 1'b0;
    m_snap_k = 0;
    m_snap_d = 32'h0;
  endfunction

  function automatic logic [63:0] model_cfg();
    logic [63:0] p;
    p = 64'h0;
    for (int i = 0; i < NUM_CFG; i++) p[i*8 +: 8] = m_cfg[i];
    return p;
  endfunction

  function automatic logic [NUM_PULSE-1:0] model_pulse();
    logic [NUM_PULSE-1:0] p;
    for (int i = 0; i < NUM_PULSE; i++) p[i] = (m_rem[i] > 0);
    return p;
  endfunction

  function automatic logic [7:0] model_read(input int a);
    int          k;
    int          lane;
    logic [31:0] w;
    if (a >= CFG_B && a < CFG_B + NUM_CFG) return m_cfg[a - CFG_B];
    if (a >= CNT_B && a < CNT_B + 4*NUM_CNT) begin
      k    = (a - CNT_B) / 4;
      lane = (a - CNT_B) % 4;
      w    = (lane != 0 && m_snap_v && m_snap_k == k) ? m_snap_d : cnt_in[k*32 +: 32];
      return w[8*(3-lane) +: 8];
    end
    if (a == STK_B) return m_sticky;
    if (a == STK_B + 1) return m_mask;
    if (a >= PUL_B && a < PUL_B + NUM_PULSE) return (m_rem[a - PUL_B] > 0) ? 8'h01 : 8'h00;
    return 8'h00;
  endfunction

  function automatic void model_step(input int a, input logic [7:0] d, input bit we,
                                     input bit re, input logic [7:0] ev);
    e_dout = model_read(a);
    e_irq  = |(m_sticky & m_mask);
    e_chg  = '0;
    if (we && a >= CFG_B && a < CFG_B + NUM_CFG) begin
      m_cfg[a - CFG_B] = d;
      e_chg[a - CFG_B] = 1'b1;
    end
    m_sticky = ev | (m_sticky & ~((we && a == STK_B) ? d : 8'h00));
    if (we && a == STK_B + 1) m_mask = d;
    for (int i = 0; i < NUM_PULSE; i++) begin
      if (we && a == PUL_B + i) m_rem[i] = PULSE_LEN;
      else if (m_rem[i] > 0) m_rem[i] = m_rem[i] - 1;
    end
    if (re && a >= CNT_B && a < CNT_B + 4*NUM_CNT && (a - CNT_B) % 4 == 0) begin
      m_snap_v = 1'b1;
      m_snap_k = (a - CNT_B) / 4;
      m_snap_d = cnt_in[m_snap_k*32 +: 32];
    end else if (we) begin
      m_snap_v = 1'b0;
    end
  endfunction

  task automatic apply(input logic [7:0] a, input logic [7:0] d, input bit we, input bit re,
                       input logic [7:0] ev);
    addr = a; dataIn = d; writeEn = we; readEn = re; event_in = ev;
    model_step(int'(a), d, we, re, ev);
    @(posedge clk);
    #1;
    chk("dataOut", dataOut, e_dout);
    chk("cfg_out", cfg_out, model_cfg());
    chk("cfg_changed", cfg_changed, e_chg);
    chk("pulse_out", pulse_out, model_pulse());
    chk("sticky_out", sticky_out, m_sticky);
    chk("irq", irq, e_irq);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_dataOut"}, dataOut, 8'h00);
    chk({tag, "_cfg_out"}, cfg_out, CFG_RST);
    chk({tag, "_cfg_changed"}, cfg_changed, 8'h00);
    chk({tag, "_pulse_out"}, pulse_out, 2'b00);
    chk({tag, "_sticky"}, sticky_out, 8'h00);
    chk({tag, "_irq"}, irq, 1'b0);
  endtask

  int          hi0;
  int          hi1;
  int          r;
  logic [7:0]  ra;

  initial begin
    reset_n = 1'b0; addr = 8'h00; dataIn = 8'h00; writeEn = 1'b0; readEn = 1'b0;
    event_in = 8'h00; cnt_in = '0;
    model_reset();
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;

    //        addr   data   we    re    ev     cnt1           cd ed     cs es     ci ei
    tbl.push_back(mk(8'h91, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0000_0000, 1'b1, 8'h11, 1'b0, 8'h00, 1'b1, 1'b0));
    tbl.push_back(mk(8'hA4, 8'h00, 1'b0, 1'b1, 8'h00, 32'h00FF_FFFF, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0));
    tbl.push_back(mk(8'hA5, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0100_0000, 1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0));
    tbl.push_back(mk(8'hA6, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0100_0000, 1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0));
    tbl.push_back(mk(8'hA7, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0100_0000, 1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0));
    tbl.push_back(mk(8'hA4, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0100_0000, 1'b1, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0));
    tbl.push_back(mk(8'hC8, 8'h00, 1'b0, 1'b0, 8'h05, 32'h0100_0000, 1'b1, 8'h00, 1'b1, 8'h05, 1'b0, 1'b0));
    tbl.push_back(mk(8'hC8, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0100_0000, 1'b1, 8'h05, 1'b1, 8'h05, 1'b0, 1'b0));
    tbl.push_back(mk(8'hC8, 8'h04, 1'b1, 1'b0, 8'h00, 32'h0100_0000, 1'b1, 8'h05, 1'b1, 8'h01, 1'b0, 1'b0));
    tbl.push_back(mk(8'hC8, 8'h01, 1'b1, 1'b0, 8'h01, 32'h0100_0000, 1'b1, 8'h01, 1'b1, 8'h01, 1'b0, 1'b0));
    tbl.push_back(mk(8'hC8, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0100_0000, 1'b1, 8'h01, 1'b1, 8'h01, 1'b0, 1'b0));
    tbl.push_back(mk(8'hC9, 8'h02, 1'b1, 1'b0, 8'h00, 32'h0100_0000, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0));
    tbl.push_back(mk(8'hC9, 8'h00, 1'b0, 1'b0, 8'h02, 32'h0100_0000, 1'b1, 8'h02, 1'b1, 8'h03, 1'b1, 1'b0));
    tbl.push_back(mk(8'hC8, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0100_0000, 1'b1, 8'h03, 1'b0, 8'h00, 1'b1, 1'b1));
    tbl.push_back(mk(8'hC8, 8'h02, 1'b1, 1'b0, 8'h00, 32'h0100_0000, 1'b1, 8'h03, 1'b1, 8'h01, 1'b1, 1'b1));
    tbl.push_back(mk(8'hC8, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0100_0000, 1'b1, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0));
    tbl.push_back(mk(8'hA4, 8'h00, 1'b0, 1'b1, 8'h00, 32'h0100_0000, 1'b1, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0));
    tbl.push_back(mk(8'h90, 8'h5A, 1'b1, 1'b0, 8'h00, 32'h0100_00FF, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0));
    tbl.push_back(mk(8'hA7, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0100_00FF, 1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0));
    tbl.push_back(mk(8'h90, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0100_00FF, 1'b1, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b0));

    foreach (tbl[n]) begin
      cnt_in[63:32] = tbl[n].c1;
      apply(tbl[n].a, tbl[n].d, tbl[n].we, tbl[n].re, tbl[n].ev);
      if (tbl[n].cd) chk($sformatf("vec%0d_dataOut", n), dataOut, tbl[n].ed);
      if (tbl[n].cs) chk($sformatf("vec%0d_sticky", n), sticky_out, tbl[n].es);
      if (tbl[n].ci) chk($sformatf("vec%0d_irq", n), irq, tbl[n].ei);
    end

    // Config strobe lasts exactly one cycle.
    apply(8'h93, 8'h3C, 1'b1, 1'b0, 8'h00);
    chk("cfg3_value", cfg_out[31:24], 8'h3C);
    chk("cfg3_strobe", cfg_changed, 8'b0000_1000);
    apply(8'h93, 8'h00, 1'b0, 1'b0, 8'h00);
    chk("cfg3_strobe_gone", cfg_changed, 8'b0000_0000);

    // Single pulse, then a rewrite on the third cycle extends it.
    hi0 = 0; hi1 = 0;
    apply(8'hF0, 8'hA5, 1'b1, 1'b0, 8'h00);
    hi0 += int'(pulse_out[0]); hi1 += int'(pulse_out[1]);
    for (int n = 0; n < 8; n++) begin
      apply(8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
      hi0 += int'(pulse_out[0]); hi1 += int'(pulse_out[1]);
    end
    chk("pulse_len_single", hi0, 4);
    hi0 = 0;
    apply(8'hF0, 8'h00, 1'b1, 1'b0, 8'h00);
    hi0 += int'(pulse_out[0]); hi1 += int'(pulse_out[1]);
    apply(8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
    hi0 += int'(pulse_out[0]); hi1 += int'(pulse_out[1]);
    apply(8'hF0, 8'h00, 1'b1, 1'b0, 8'h00);
    hi0 += int'(pulse_out[0]); hi1 += int'(pulse_out[1]);
    for (int n = 0; n < 8; n++) begin
      apply(8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
      hi0 += int'(pulse_out[0]); hi1 += int'(pulse_out[1]);
    end
    chk("pulse_len_extended", hi0, 6);
    chk("pulse1_idle", hi1, 0);

    // Asynchronous reset in the middle of a pulse, with a valid snapshot and non-default config.
    cnt_in[95:64] = 32'h1234_5678;
    apply(8'hA8, 8'h00, 1'b0, 1'b1, 8'h80);
    apply(8'hF1, 8'h00, 1'b1, 1'b0, 8'h00);
    apply(8'hF1, 8'h00, 1'b0, 1'b0, 8'h00);
    chk("pulse1_before_reset", pulse_out[1], 1'b1);
    #3;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    #2;
    reset_n = 1'b1;
    model_reset();
    cnt_in[95:64] = 32'h1234_AABB;
    apply(8'hAB, 8'h00, 1'b0, 1'b0, 8'h00);
    chk("snap_cleared_by_reset", dataOut, 8'hBB);

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      for (int k = 0; k < NUM_CNT; k++) begin
        if ($urandom_range(0, 3) == 0) cnt_in[k*32 +: 32] = cnt_in[k*32 +: 32] + 32'($urandom_range(1, 400));
        if ($urandom_range(0, 63) == 0) cnt_in[k*32 +: 32] = $urandom;
      end
      r = int'($urandom_range(0, 5));
      case (r)
        0:       ra = 8'(CFG_B + int'($urandom_range(0, NUM_CFG - 1)));
        1, 2:    ra = 8'(CNT_B + int'($urandom_range(0, 4*NUM_CNT - 1)));
        3:       ra = 8'(STK_B + int'($urandom_range(0, 1)));
        4:       ra = 8'(PUL_B + int'($urandom_range(0, NUM_PULSE)));
        default: ra = 8'($urandom);
      endcase
      apply(ra, 8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
